cache_flush_seq: RTL and testbench
==================================

CACHE_FLUSH_SEQ -- requirements
Module: cache_flush_seq

Interface
REQ-001 SHALL have parameter NUMLINES, default 512, meaning sets per way (power of 2, >=2).
REQ-002 SHALL have parameter NUMWAYS, default 4, meaning ways per set (>=1).
REQ-003 SHALL have port clk  input  1  clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port FlushReq  input  1  request to write back all dirty lines; level, sampled in IDLE only.
REQ-006 SHALL have port InvalReq  input  1  request to clear all valid bits; level, sampled in IDLE only.
REQ-007 SHALL have port LineDirty  input  1  OR of per-way DirtyWay outputs, valid the cycle after a READ cycle.
REQ-008 SHALL have port BusAck  input  1  bus accepted and completed the line writeback.
REQ-009 SHALL have port SelFlush  output  1  array address/way taken from FlushAdr/FlushWay.
REQ-010 SHALL have port FlushAdr  output  log2(NUMLINES)  set index under flush.
REQ-011 SHALL have port FlushWay  output  NUMWAYS  one-hot way under flush.
REQ-012 SHALL have port CacheEn  output  1  array read/write enable.
REQ-013 SHALL have port SelWriteback  output  1  array output selects the flushed way for writeback.
REQ-014 SHALL have port BusWriteReq  output  1  line writeback request to the bus.
REQ-015 SHALL have port ClearDirty  output  1  clear dirty bit of the selected way/set.
REQ-016 SHALL have port InvalidateCache  output  1  one-cycle pulse clearing all valid bits.
REQ-017 SHALL have port Busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port FlushDone  output  1  one-cycle pulse at end of a flush.

Function
REQ-019 SHALL implement states IDLE, READ, CHECK, WRITEBACK, CLEAR, DONE.
REQ-020 IDLE: FlushReq=1 -> READ with FlushAdr=0, FlushWay=1; else InvalReq=1 -> InvalidateCache=1 this cycle, stay IDLE.
REQ-021 READ: SelFlush=1, CacheEn=1; next state CHECK.
REQ-022 CHECK: SelFlush=1, CacheEn=0 (read data held); LineDirty=1 -> WRITEBACK; else advance (REQ-025).
REQ-023 WRITEBACK: SelFlush=1, SelWriteback=1, BusWriteReq=1 held until cycle with BusAck=1, then CLEAR; BusAck outside WRITEBACK ignored.
REQ-024 CLEAR: SelFlush=1, CacheEn=1, ClearDirty=1 for exactly one cycle; then advance.
REQ-025 Advance: if FlushWay not MSB, rotate FlushWay left one -> READ; else FlushWay=1, FlushAdr+1 -> READ; if FlushAdr=NUMLINES-1 and FlushWay MSB -> DONE, FlushAdr/FlushWay unchanged.
REQ-026 FlushAdr SHALL never wrap past NUMLINES-1 during a flush.
REQ-027 DONE: FlushDone=1 one cycle, then IDLE; InvalidateCache=1 in DONE if InvalReq was 1 in the accepting IDLE cycle.
REQ-028 FlushReq and InvalReq both high in IDLE: flush runs, invalidate deferred to DONE per REQ-027.
REQ-029 Clean-cache flush latency: FlushDone exactly 2*NUMLINES*NUMWAYS+1 cycles after accepting edge.
REQ-030 Each dirty line adds (cycles until BusAck)+1 (CLEAR) cycles.
REQ-031 All outputs SHALL be registered-state decodes, no combinational path from inputs except BusWriteReq deassert follows state.

Reset
REQ-032 reset SHALL force IDLE, FlushAdr=0, FlushWay=1, deferred-invalidate flag=0 in any state, including mid-WRITEBACK.
REQ-033 During/after reset all outputs 0 except FlushWay=1 and FlushAdr=0.
REQ-034 Flush aborted by reset SHALL NOT pulse FlushDone.

Structure
REQ-035 State enum type SHALL live in the shared cvw package.
REQ-036 Set/way counter SHALL be one sub-module flush_ctr (set counter + one-hot way rotator, last flag output).
REQ-037 Way count NUMWAYS=1 SHALL degenerate to set-only counting.

Verification
REQ-038 NUMLINES=4, NUMWAYS=2, all clean, FlushReq 1 cycle -> FlushDone at cycle 17, BusWriteReq never high.
REQ-039 Same, set 2 way 1 dirty, BusAck 3 cycles after request -> one BusWriteReq with FlushAdr=2, FlushWay=2'b10; ClearDirty one cycle; FlushDone at cycle 21.
REQ-040 InvalReq only in IDLE -> InvalidateCache single pulse same cycle, Busy stays 0.
REQ-041 FlushReq+InvalReq together -> InvalidateCache coincident with FlushDone, not before.
REQ-042 reset asserted in WRITEBACK -> next cycle IDLE, BusWriteReq=0, no FlushDone, FlushAdr=0.
REQ-043 All sets dirty, BusAck immediate -> FlushAdr visits 0..3 in order, 8 writebacks, no wrap.

Source files
------------

// File: rtl/cache_flush_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_flush_seq_pkg
// Brief   : Shared state type and encodings for the cache flush sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package cache_flush_seq_pkg;

    typedef logic [2:0] flushStateT;

    localparam flushStateT c_IDLE      = 3'd0;
    localparam flushStateT c_READ      = 3'd1;
    localparam flushStateT c_CHECK     = 3'd2;
    localparam flushStateT c_WRITEBACK = 3'd3;
    localparam flushStateT c_CLEAR     = 3'd4;
    localparam flushStateT c_DONE      = 3'd5;

    // States in which the array address/way mux points at the flush counter.
    function automatic logic isSelState(input flushStateT s);
        return (s == c_READ) || (s == c_CHECK) || (s == c_WRITEBACK) || (s == c_CLEAR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_flush_seq_flush_ctr.sv
`default_nettype none
// ============================================================================
// Module  : flush_ctr
// Brief   : Set counter plus one-hot way rotator; flags the final set/way.
// Revision: 1.0 - initial release
// ============================================================================
module flush_ctr #(
    parameter int NUMLINES = 512,
    parameter int NUMWAYS  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_init,
    input  logic                        i_advance,
    output logic [$clog2(NUMLINES)-1:0] o_adr,
    output logic [NUMWAYS-1:0]          o_way,
    output logic                        o_last
);

    localparam int                  c_ADRW = $clog2(NUMLINES);
    localparam logic [NUMWAYS-1:0]  c_WAY0 = NUMWAYS'(1);
    localparam logic [c_ADRW-1:0]   c_ADRMAX = c_ADRW'(NUMLINES - 1);

    logic [c_ADRW-1:0]  r_adr;
    logic [NUMWAYS-1:0] r_way;
    logic [NUMWAYS-1:0] w_wayRot;

    generate
        if (NUMWAYS > 1) begin : g_multiWay
            assign w_wayRot = {r_way[NUMWAYS-2:0], 1'b0};
        end else begin : g_singleWay
            assign w_wayRot = r_way;
        end
    endgenerate

    // Wrapping past the top way steps the set; the caller never advances on the last line.
    always_ff @(posedge clk) begin
        if (reset || i_init) begin
            r_adr <= '0;
            r_way <= c_WAY0;
        end else if (i_advance) begin
            if (r_way[NUMWAYS-1]) begin
                r_way <= c_WAY0;
                r_adr <= r_adr + c_ADRW'(1);
            end else begin
                r_way <= w_wayRot;
            end
        end
    end

    assign o_adr  = r_adr;
    assign o_way  = r_way;
    assign o_last = (r_adr == c_ADRMAX) && r_way[NUMWAYS-1];

endmodule
`default_nettype wire

// File: rtl/cache_flush_seq.sv
`default_nettype none
// ============================================================================
// Module  : cache_flush_seq
// Brief   : Walks every set/way, writing back dirty lines, with optional invalidate.
// Revision: 1.0 - initial release
// ============================================================================
module cache_flush_seq
    import cache_flush_seq_pkg::*;
#(
    parameter int NUMLINES = 512,
    parameter int NUMWAYS  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        FlushReq,
    input  logic                        InvalReq,
    input  logic                        LineDirty,
    input  logic                        BusAck,
    output logic                        SelFlush,
    output logic [$clog2(NUMLINES)-1:0] FlushAdr,
    output logic [NUMWAYS-1:0]          FlushWay,
    output logic                        CacheEn,
    output logic                        SelWriteback,
    output logic                        BusWriteReq,
    output logic                        ClearDirty,
    output logic                        InvalidateCache,
    output logic                        Busy,
    output logic                        FlushDone
);

    flushStateT r_state;
    flushStateT w_nextState;
    logic       r_invalPending;
    logic       w_last;
    logic       w_init;
    logic       w_stepPoint;
    logic       w_advance;
    logic       w_run;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // An invalidate requested together with a flush is held until the flush ends.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_invalPending <= 1'b0;
        end else if ((r_state == c_IDLE) && FlushReq) begin
            r_invalPending <= InvalReq;
        end else if (r_state == c_DONE) begin
            r_invalPending <= 1'b0;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:      if (FlushReq) w_nextState = c_READ;
            c_READ:      w_nextState = c_CHECK;
            c_CHECK: begin
                if (LineDirty)   w_nextState = c_WRITEBACK;
                else if (w_last) w_nextState = c_DONE;
                else             w_nextState = c_READ;
            end
            c_WRITEBACK: if (BusAck) w_nextState = c_CLEAR;
            c_CLEAR:     w_nextState = w_last ? c_DONE : c_READ;
            c_DONE:      w_nextState = c_IDLE;
            default:     w_nextState = c_IDLE;
        endcase
    end

    assign w_init      = (r_state == c_IDLE) && FlushReq;
    assign w_stepPoint = ((r_state == c_CHECK) && !LineDirty) || (r_state == c_CLEAR);
    assign w_advance   = w_stepPoint && !w_last;

    flush_ctr #(
        .NUMLINES (NUMLINES),
        .NUMWAYS  (NUMWAYS)
    ) u_flushCtr (
        .clk       (clk),
        .reset     (reset),
        .i_init    (w_init),
        .i_advance (w_advance),
        .o_adr     (FlushAdr),
        .o_way     (FlushWay),
        .o_last    (w_last)
    );

    // Outputs are held low while reset is asserted, whatever state was left behind.
    assign w_run           = !reset;
    assign SelFlush        = w_run && isSelState(r_state);
    assign CacheEn         = w_run && ((r_state == c_READ) || (r_state == c_CLEAR));
    assign SelWriteback    = w_run && (r_state == c_WRITEBACK);
    assign BusWriteReq     = w_run && (r_state == c_WRITEBACK);
    assign ClearDirty      = w_run && (r_state == c_CLEAR);
    assign Busy            = w_run && (r_state != c_IDLE);
    assign FlushDone       = w_run && (r_state == c_DONE);
    assign InvalidateCache = w_run && (((r_state == c_IDLE) && InvalReq && !FlushReq) ||
                                       ((r_state == c_DONE) && r_invalPending));

endmodule
`default_nettype wire

// File: tb/tb_cache_flush_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_flush_seq
// Brief   : Self-checking bench with a dirty-array/bus responder and flush model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cache_flush_seq;

    localparam int L = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         reset, FlushReq, InvalReq, LineDirty, BusAck;
    logic         SelFlush, CacheEn, SelWriteback, BusWriteReq, ClearDirty;
    logic         InvalidateCache, Busy, FlushDone;
    logic [1:0]   FlushAdr;
    logic [W-1:0] FlushWay;

    int nChecks = 0;
    int nFail   = 0;

    bit dirty [L][W];
    int fixedDelay = 0;
    bit spurious   = 0;
    bit respOn     = 0;
    int delayQ[$];

    always #5 clk = ~clk;

    cache_flush_seq #(.NUMLINES(L), .NUMWAYS(W)) dut (
        .clk(clk), .reset(reset), .FlushReq(FlushReq), .InvalReq(InvalReq),
        .LineDirty(LineDirty), .BusAck(BusAck), .SelFlush(SelFlush),
        .FlushAdr(FlushAdr), .FlushWay(FlushWay), .CacheEn(CacheEn),
        .SelWriteback(SelWriteback), .BusWriteReq(BusWriteReq),
        .ClearDirty(ClearDirty), .InvalidateCache(InvalidateCache),
        .Busy(Busy), .FlushDone(FlushDone)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int wayIdx(input logic [W-1:0] w);
        for (int i = 0; i < W; i++) if (w[i]) return i;
        return 0;
    endfunction

    // Array and bus behaviour: LineDirty answers the READ one cycle later, BusAck after a chosen delay.
    initial begin : responder
        bit pendRead, pendVal;
        int wbCnt, curDelay;
        LineDirty = 1'b0; BusAck = 1'b0;
        pendRead = 0; pendVal = 0; wbCnt = 0; curDelay = 1;
        forever begin
            @(negedge clk);
            if (respOn) begin
                LineDirty = pendRead ? pendVal : (spurious && ($urandom_range(0, 1) == 1));
                pendRead  = CacheEn && !ClearDirty;
                if (pendRead) pendVal = dirty[FlushAdr][wayIdx(FlushWay)];
                if (ClearDirty) dirty[FlushAdr][wayIdx(FlushWay)] = 1'b0;
                if (BusWriteReq) begin
                    if (wbCnt == 0) begin
                        curDelay = (fixedDelay > 0) ? fixedDelay : int'($urandom_range(1, 4));
                        delayQ.push_back(curDelay);
                    end
                    wbCnt++;
                    BusAck = (wbCnt == curDelay);
                end else begin
                    wbCnt  = 0;
                    BusAck = spurious && ($urandom_range(0, 3) == 0);
                end
            end
        end
    end

    // expLat < 0: latency taken from the model (clean walk plus per-writeback cost).
    task automatic runFlush(input string tag, input bit withInval, input int expLat);
        int expOrder[$], obsOrder[$];
        int doneCyc, doneCnt, invCnt, invAtDone, clrCnt, wrapErr, prevAdr, maxAdr, cyc, lat;
        bit prevBwr, orderOk, anyDirty;
        for (int a = 0; a < L; a++)
            for (int w = 0; w < W; w++)
                if (dirty[a][w]) expOrder.push_back(a * W + w);
        delayQ.delete();
        doneCyc = -1; doneCnt = 0; invCnt = 0; invAtDone = 0; clrCnt = 0;
        wrapErr = 0; prevAdr = 0; maxAdr = 0; prevBwr = 0;
        @(negedge clk);
        #1 FlushReq = 1'b1; InvalReq = withInval;
        #1 check({tag, " inval not at accept"}, InvalidateCache, 0);
        @(posedge clk);
        cyc = 0;
        while (cyc < 3000 && (doneCyc < 0 || cyc < doneCyc + 2)) begin
            @(negedge clk);
            cyc++;
            FlushReq = 1'b0; InvalReq = 1'b0;
            if (BusWriteReq && !prevBwr) obsOrder.push_back(FlushAdr * W + wayIdx(FlushWay));
            prevBwr = BusWriteReq;
            if (SelFlush) begin
                if (FlushAdr < prevAdr) wrapErr++;
                prevAdr = FlushAdr;
                if (FlushAdr > maxAdr) maxAdr = FlushAdr;
            end
            if (ClearDirty) clrCnt++;
            if (InvalidateCache) begin
                invCnt++;
                if (FlushDone) invAtDone++;
            end
            if (FlushDone) begin
                doneCnt++;
                if (doneCyc < 0) doneCyc = cyc;
            end
        end
        lat = 2 * L * W + 1;
        foreach (delayQ[i]) lat += delayQ[i] + 1;
        if (expLat >= 0) lat = expLat;
        orderOk = (obsOrder.size() == expOrder.size());
        if (orderOk) foreach (expOrder[i]) if (obsOrder[i] != expOrder[i]) orderOk = 0;
        anyDirty = 0;
        for (int a = 0; a < L; a++) for (int w = 0; w < W; w++) anyDirty |= dirty[a][w];
        check({tag, " done cycle"}, doneCyc, lat);
        check({tag, " done pulses"}, doneCnt, 1);
        check({tag, " writeback count"}, obsOrder.size(), expOrder.size());
        check({tag, " writeback order ok"}, orderOk, 1);
        check({tag, " clear pulses"}, clrCnt, expOrder.size());
        check({tag, " dirty left"}, anyDirty, 0);
        check({tag, " adr wrap"}, wrapErr, 0);
        check({tag, " max adr"}, maxAdr, L - 1);
        check({tag, " inval count"}, invCnt, withInval);
        check({tag, " inval at done"}, invAtDone, withInval);
        check({tag, " idle after"}, Busy, 0);
    endtask

    task automatic clearDirty();
        for (int a = 0; a < L; a++) for (int w = 0; w < W; w++) dirty[a][w] = 1'b0;
    endtask

    typedef struct {
        bit inval;
        bit dirtyIn;
        bit ack;
        bit expInv;
    } idleVecT;

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        idleVecT vecs[8];
        int waitCyc;
        int doneSeen;
        for (int i = 0; i < 8; i++) begin
            vecs[i].inval   = i[2];
            vecs[i].dirtyIn = i[1];
            vecs[i].ack     = i[0];
            vecs[i].expInv  = i[2];
        end

        reset = 1'b1; FlushReq = 1'b0; InvalReq = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset ctrl outputs",
              {SelFlush, CacheEn, SelWriteback, BusWriteReq, ClearDirty, InvalidateCache, Busy, FlushDone}, 0);
        check("reset FlushWay", FlushWay, 1);
        check("reset FlushAdr", FlushAdr, 0);
        @(negedge clk);
        reset = 1'b0; InvalReq = 1'b0;

        // Idle behaviour: only InvalReq matters, and only as a same-cycle pulse.
        foreach (vecs[i]) begin
            @(negedge clk);
            #1 InvalReq = vecs[i].inval; LineDirty = vecs[i].dirtyIn; BusAck = vecs[i].ack;
            #1 check($sformatf("idle vec%0d inval", i), InvalidateCache, vecs[i].expInv);
            check($sformatf("idle vec%0d busy", i), {Busy, SelFlush, BusWriteReq}, 0);
            @(posedge clk);
            #1 check($sformatf("idle vec%0d stay", i), Busy, 0);
            InvalReq = 1'b0;
        end
        @(negedge clk);
        #1 check("idle inval released", InvalidateCache, 0);

        respOn = 1;
        clearDirty();
        fixedDelay = 1; spurious = 0;
        runFlush("clean", 0, 17);

        clearDirty();
        dirty[2][1] = 1'b1;
        fixedDelay = 3;
        runFlush("one dirty", 0, 21);

        for (int a = 0; a < L; a++) for (int w = 0; w < W; w++) dirty[a][w] = 1'b1;
        fixedDelay = 1;
        runFlush("all dirty", 0, 33);

        clearDirty();
        dirty[0][1] = 1'b1;
        fixedDelay = 2;
        runFlush("flush+inval", 1, 17 + 3);

        // Reset in the middle of a writeback.
        clearDirty();
        dirty[1][0] = 1'b1;
        fixedDelay = 10;
        @(negedge clk);
        #1 FlushReq = 1'b1;
        @(negedge clk);
        FlushReq = 1'b0;
        waitCyc = 0;
        while (!BusWriteReq && waitCyc < 200) begin
            @(negedge clk);
            waitCyc++;
        end
        check("rst-wb reached writeback", BusWriteReq, 1);
        check("rst-wb writeback adr", FlushAdr, 1);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 check("rst-wb BusWriteReq", BusWriteReq, 0);
        check("rst-wb Busy", Busy, 0);
        check("rst-wb FlushAdr", FlushAdr, 0);
        check("rst-wb FlushWay", FlushWay, 1);
        check("rst-wb FlushDone", FlushDone, 0);
        @(negedge clk);
        reset = 1'b0;
        doneSeen = 0;
        repeat (60) begin
            @(negedge clk);
            if (FlushDone || Busy) doneSeen++;
        end
        check("rst-wb no resume/done", doneSeen, 0);

        fixedDelay = 0; spurious = 1;
        for (int r = 0; r < 6; r++) begin
            for (int a = 0; a < L; a++)
                for (int w = 0; w < W; w++)
                    dirty[a][w] = ($urandom_range(0, 2) == 0);
            runFlush($sformatf("rand%0d", r), bit'($urandom_range(0, 1)), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
`default_nettype wire
